pe_acc: RTL and testbench

PE_ACC -- requirements
Module: pe_acc

---
 rtl/pe_pkg.sv | 15 +
 rtl/pe_sat_add.sv | 24 ++
 rtl/pe_acc.sv | 136 +++++++++++++
 tb/tb_pe_acc.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types for the pe_acc processing element: dataflow mode and control state.
package pe_pkg;

    typedef enum logic {
        MODE_OS = 1'b0,
        MODE_WS = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/pe_sat_add.sv
// Signed ACC_W adder with overflow detect; clamps to the signed range when SATURATE=1, else wraps.
module pe_sat_add #(
    parameter int ACC_W    = 24,
    parameter int SATURATE = 1
) (
    input  logic signed [ACC_W-1:0] x,
    input  logic signed [ACC_W-1:0] y,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);

    logic signed [ACC_W-1:0] raw;

    always_comb begin
        raw = x + y;
        // Overflow only when both operands share a sign the result does not.
        ovf = (x[ACC_W-1] == y[ACC_W-1]) && (raw[ACC_W-1] != x[ACC_W-1]);
        sum = raw;
        if ((SATURATE != 0) && ovf) begin
            sum = x[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/pe_acc.sv
// Systolic-array processing element: output-stationary accumulate/drain or
// weight-stationary partial-sum MAC, with registered operand forwarding.
module pe_acc
    import pe_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int ACC_W    = 2*WIDTH+8,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [WIDTH-1:0] a_in,
    input  logic             a_valid_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             b_valid_in,
    input  logic             load_w,
    input  logic [ACC_W-1:0] psum_in,
    input  logic             psum_valid_in,
    input  logic             clear,
    input  logic             drain,
    output logic [WIDTH-1:0] a_out,
    output logic             a_valid_out,
    output logic [WIDTH-1:0] b_out,
    output logic             b_valid_out,
    output logic [ACC_W-1:0] psum_out,
    output logic             psum_valid_out,
    output logic             busy,
    output logic             sat_flag,
    output logic [1:0]       state_dbg
);

    // Handshake: every *_valid qualifies its data in the same cycle; there is no
    // backpressure, so a valid is consumed on the rising edge it is seen high.
    // A drain that coincides with psum_valid_in is a protocol violation: the
    // local accumulator wins and the upstream partial sum is dropped.

    state_e                   state, state_nxt;
    mode_e                    mode_q, mode_eff;
    logic signed [ACC_W-1:0]  acc;
    logic signed [WIDTH-1:0]  w;
    logic signed [WIDTH-1:0]  mul_b;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]  add_x, add_y, add_sum;
    logic                     add_ovf;
    logic                     ws, mac, os_drain, os_pass;

    always_comb begin
        // Mode is live while idle and frozen once a run has started.
        mode_eff = (state == IDLE) ? mode_e'(mode) : mode_q;
        ws       = (mode_eff == MODE_WS);
        mac      = ws ? a_valid_in : (a_valid_in && b_valid_in);
        mul_b    = ws ? w : b_in;
        prod     = (2*WIDTH)'(signed'(a_in)) * (2*WIDTH)'(mul_b);
        add_x    = ws ? psum_in : acc;
        add_y    = mac ? ACC_W'(prod) : '0;
        os_drain = !ws && drain && !clear && ((state == RUN) || ((state == IDLE) && mac));
        os_pass  = !ws && (state == IDLE) && !os_drain && !clear && psum_valid_in;
    end

    pe_sat_add #(
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
    ) u_add (
        .x   (add_x),
        .y   (add_y),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (clear)         state_nxt = IDLE;
                else if (os_drain) state_nxt = DRAIN;
                else if (mac)      state_nxt = RUN;
            end
            RUN: begin
                if (clear)         state_nxt = IDLE;
                else if (os_drain) state_nxt = DRAIN;
            end
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            mode_q         <= MODE_OS;
            acc            <= '0;
            w              <= '0;
            sat_flag       <= 1'b0;
            a_out          <= '0;
            a_valid_out    <= 1'b0;
            b_out          <= '0;
            b_valid_out    <= 1'b0;
            psum_out       <= '0;
            psum_valid_out <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) mode_q <= mode_e'(mode);

            a_valid_out <= a_valid_in;
            b_valid_out <= b_valid_in;
            if (a_valid_in) a_out <= a_in;
            if (b_valid_in) b_out <= b_in;

            // The MAC in a load_w cycle reads w before this update lands.
            if (ws && load_w) w <= b_in;

            if (clear || os_drain)  acc <= '0;
            else if (!ws && mac)    acc <= add_sum;

            if (clear)              sat_flag <= 1'b0;
            else if (mac && add_ovf) sat_flag <= 1'b1;

            psum_valid_out <= 1'b0;
            if (os_drain) begin
                psum_out       <= add_sum;
                psum_valid_out <= 1'b1;
            end else if (os_pass) begin
                psum_out       <= psum_in;
                psum_valid_out <= 1'b1;
            end else if (ws && mac) begin
                psum_out       <= add_sum;
                psum_valid_out <= psum_valid_in;
            end
        end
    end

endmodule

// File: tb/tb_pe_acc.sv
// Directed bench for pe_acc: one 24-bit instance plus two 16-bit instances
// (saturating and wrapping) sharing the same stimulus.
module tb_pe_acc;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus signals ----------------
    logic               mode = 1'b0;
    logic signed [7:0]  a_in = '0;
    logic               a_valid_in = 1'b0;
    logic signed [7:0]  b_in = '0;
    logic               b_valid_in = 1'b0;
    logic               load_w = 1'b0;
    logic signed [23:0] psum_in = '0;
    logic               psum_valid_in = 1'b0;
    logic               clear = 1'b0;
    logic               drain = 1'b0;
    logic [15:0]        psum_in16;
    assign psum_in16 = psum_in[15:0];

    // ---------------- DUT outputs ----------------
    logic signed [7:0]  a_out, b_out;
    logic               a_valid_out, b_valid_out;
    logic signed [23:0] p24;
    logic               pv24, busy, sat24;
    logic [1:0]         st24;
    logic signed [7:0]  a_out_s, b_out_s, a_out_w, b_out_w;
    logic               av_s, bv_s, av_w, bv_w;
    logic signed [15:0] p16s, p16w;
    logic               pv16s, pv16w, busy_s, busy_w, sat16s, sat16w;
    logic [1:0]         st16s, st16w;

    pe_acc #(.WIDTH(8), .ACC_W(24), .SATURATE(1)) u24 (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in), .b_valid_in(b_valid_in),
        .load_w(load_w), .psum_in(psum_in), .psum_valid_in(psum_valid_in),
        .clear(clear), .drain(drain),
        .a_out(a_out), .a_valid_out(a_valid_out), .b_out(b_out), .b_valid_out(b_valid_out),
        .psum_out(p24), .psum_valid_out(pv24), .busy(busy), .sat_flag(sat24), .state_dbg(st24)
    );

    pe_acc #(.WIDTH(8), .ACC_W(16), .SATURATE(1)) u16s (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in), .b_valid_in(b_valid_in),
        .load_w(load_w), .psum_in(psum_in16), .psum_valid_in(psum_valid_in),
        .clear(clear), .drain(drain),
        .a_out(a_out_s), .a_valid_out(av_s), .b_out(b_out_s), .b_valid_out(bv_s),
        .psum_out(p16s), .psum_valid_out(pv16s), .busy(busy_s), .sat_flag(sat16s), .state_dbg(st16s)
    );

    pe_acc #(.WIDTH(8), .ACC_W(16), .SATURATE(0)) u16w (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in), .b_valid_in(b_valid_in),
        .load_w(load_w), .psum_in(psum_in16), .psum_valid_in(psum_valid_in),
        .clear(clear), .drain(drain),
        .a_out(a_out_w), .a_valid_out(av_w), .b_out(b_out_w), .b_valid_out(bv_w),
        .psum_out(p16w), .psum_valid_out(pv16w), .busy(busy_w), .sat_flag(sat16w), .state_dbg(st16w)
    );

    // ---------------- counters / scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic signed [23:0] exp_q[$];

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    // Every valid psum on the 24-bit instance must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && pv24 === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                assert (exp_q.size() != 0)
                else $error("FAIL unexpected_psum: observed valid with %0d required no output", p24);
            end else begin
                logic signed [23:0] e;
                e = exp_q.pop_front();
                check("psum_out", p24, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ab(input logic signed [7:0] a, input logic av,
                            input logic signed [7:0] b, input logic bv);
        a_in = a; a_valid_in = av; b_in = b; b_valid_in = bv;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset state
        tick(); tick();
        check("rst_psum_valid", pv24, 0);
        check("rst_busy", busy, 0);
        check("rst_state", st24, 0);
        rst_n = 1'b1;
        tick();

        // OS idle pass-through
        psum_in = 24'sd42; psum_valid_in = 1'b1;
        exp_q.push_back(24'sd42);
        tick();
        psum_valid_in = 1'b0;
        check("pass_busy", busy, 0);
        tick();

        // OS accumulate 3 * -4 for four cycles, then drain
        drive_ab(8'sd3, 1'b1, -8'sd4, 1'b1);
        tick();
        check("fwd_a_out", a_out, 3);
        check("fwd_b_out", b_out, -4);
        check("fwd_a_valid", a_valid_out, 1);
        check("run_busy", busy, 1);
        tick(); tick(); tick();
        drive_ab(8'sd77, 1'b0, -8'sd4, 1'b0);
        drain = 1'b1;
        exp_q.push_back(-24'sd48);
        tick();
        drain = 1'b0;
        check("hold_a_out", a_out, 3);
        check("hold_a_valid", a_valid_out, 0);
        check("drain_state", st24, 2);
        tick();
        check("post_drain_valid", pv24, 0);
        check("post_drain_busy", busy, 0);

        // clear + drain in RUN: clear wins, accumulator zeroed
        drive_ab(8'sd10, 1'b1, 8'sd10, 1'b1);
        tick();
        drive_ab(8'sd0, 1'b0, 8'sd0, 1'b0);
        clear = 1'b1; drain = 1'b1;
        tick();
        clear = 1'b0; drain = 1'b0;
        check("clr_drain_state", st24, 0);
        drive_ab(8'sd1, 1'b1, 8'sd1, 1'b1);
        drain = 1'b1;
        exp_q.push_back(24'sd1);
        tick();
        drive_ab(8'sd0, 1'b0, 8'sd0, 1'b0);
        drain = 1'b0;
        tick();

        // Saturation: -128 * -128 twice
        drive_ab(-8'sd128, 1'b1, -8'sd128, 1'b1);
        tick(); tick();
        drive_ab(8'sd0, 1'b0, 8'sd0, 1'b0);
        check("sat16s_flag", sat16s, 1);
        check("sat16w_flag", sat16w, 1);
        check("sat24_flag", sat24, 0);
        drain = 1'b1;
        exp_q.push_back(24'sd32768);
        tick();
        drain = 1'b0;
        check("sat16s_psum", p16s, 32767);
        check("sat16s_valid", pv16s, 1);
        check("sat16w_psum", p16w, -32768);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("sat_clear", sat16s, 0);

        // Mode change outside IDLE is ignored
        drive_ab(8'sd2, 1'b1, 8'sd2, 1'b1);
        tick();
        mode = 1'b1;
        drive_ab(8'sd2, 1'b1, 8'sd3, 1'b1);
        tick();
        drive_ab(8'sd0, 1'b0, 8'sd0, 1'b0);
        drain = 1'b1;
        exp_q.push_back(24'sd10);
        tick();
        drain = 1'b0;
        tick();

        // WS: load weight 5, then 7*5 + 100
        load_w = 1'b1; b_in = 8'sd5;
        tick();
        load_w = 1'b0;
        a_in = 8'sd7; a_valid_in = 1'b1; psum_in = 24'sd100; psum_valid_in = 1'b1;
        exp_q.push_back(24'sd135);
        tick();
        load_w = 1'b1; b_in = 8'sd9;
        a_in = 8'sd2; psum_in = 24'sd1;
        exp_q.push_back(24'sd11);
        tick();
        load_w = 1'b0;
        psum_valid_in = 1'b0;
        tick();
        check("ws_novalid", pv24, 0);
        psum_in = 24'sd0; psum_valid_in = 1'b1;
        exp_q.push_back(24'sd18);
        tick();
        a_valid_in = 1'b0; psum_valid_in = 1'b0;
        check("ws_busy", busy, 1);
        mode = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();

        // Asynchronous reset mid-RUN with acc = 500
        drive_ab(8'sd20, 1'b1, 8'sd25, 1'b1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_a_out", a_out, 0);
        check("arst_a_valid", a_valid_out, 0);
        check("arst_b_out", b_out, 0);
        check("arst_psum", p24, 0);
        check("arst_state", st24, 0);
        drive_ab(8'sd0, 1'b0, 8'sd0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", pv24, 0);
        check("post_rst_busy", busy, 0);
        drive_ab(8'sd1, 1'b1, 8'sd1, 1'b1);
        drain = 1'b1;
        exp_q.push_back(24'sd1);
        tick();
        drive_ab(8'sd0, 1'b0, 8'sd0, 1'b0);
        drain = 1'b0;
        tick(); tick();

        // ---------------- final report ----------------
        check("exp_q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
